// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the next-PC sequencer: FSM state codes and default vectors.
package pc_seq_pkg;

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_TRAP = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;
   localparam logic [31:0] DEF_STEP      = 32'h0000_0004;

endpackage

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the PC the register loads next from stall/jump/branch/trap/halt
// requests, and keeps the exception PC, pending-interrupt latch and run/trap/halt state.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int            WL        = 32,
   parameter logic [WL-1:0] STEP      = WL'(DEF_STEP),
   parameter logic [WL-1:0] RESET_VEC = WL'(DEF_RESET_VEC),
   parameter logic [WL-1:0] TRAP_VEC  = WL'(DEF_TRAP_VEC)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [WL-1:0] PC,
   input  logic          stall,
   input  logic          jump,
   input  logic [WL-1:0] jump_target,
   input  logic          branch_taken,
   input  logic [WL-1:0] branch_target,
   input  logic          irq,
   input  logic          eret,
   input  logic          halt_req,
   output logic [WL-1:0] nextPC,
   output logic [WL-1:0] epc,
   output logic          irq_ack,
   output logic [1:0]    state
);

   logic [WL-1:0] seq, norm, trap_epc;
   logic [1:0]    nxt_state;
   logic          pend, take_trap, intr;

   assign seq  = PC + STEP;
   assign norm = jump ? jump_target : (branch_taken ? branch_target : seq);
   assign intr = irq | pend;

   always_comb begin
      nextPC    = norm;
      nxt_state = state;
      take_trap = 1'b0;
      trap_epc  = norm;
      case (state)
         ST_TRAP: begin
            if (stall) begin
               nextPC = PC;
            end else if (eret) begin
               nextPC    = epc;
               nxt_state = ST_RUN;
            end else if (halt_req) begin
               nextPC    = PC;
               nxt_state = ST_HALT;
            end
         end
         ST_HALT: begin
            // Halted core wakes only on interrupt; it resumes after the halted instruction.
            nextPC = PC;
            if (intr) begin
               nextPC    = TRAP_VEC;
               nxt_state = ST_TRAP;
               take_trap = 1'b1;
               trap_epc  = seq;
            end
         end
         default: begin
            // RUN, and the unused code 3 which falls back to RUN.
            nxt_state = ST_RUN;
            if (stall) begin
               nextPC = PC;
            end else if (intr) begin
               nextPC    = TRAP_VEC;
               nxt_state = ST_TRAP;
               take_trap = 1'b1;
            end else if (halt_req) begin
               nextPC    = PC;
               nxt_state = ST_HALT;
            end
         end
      endcase
      if (RST) begin
         nextPC = RESET_VEC;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_RUN;
         epc     <= '0;
         pend    <= 1'b0;
         irq_ack <= 1'b0;
      end else begin
         state   <= nxt_state;
         irq_ack <= take_trap;
         if (take_trap) begin
            epc  <= trap_epc;
            pend <= 1'b0;
         end else begin
            pend <= pend | irq;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then random stimulus
// checked every cycle against a mode-level reference model.
module tb_pc_sequencer;

   logic        CLK = 1'b0;
   logic        RST, stall, jump, branch_taken, irq, eret, halt_req;
   logic [31:0] PC, jump_target, branch_target;
   logic [31:0] nextPC, epc;
   logic        irq_ack;
   logic [1:0]  state;

   int errors = 0;
   int checks = 0;

   pc_sequencer dut (
      .CLK(CLK), .RST(RST), .PC(PC), .stall(stall), .jump(jump), .jump_target(jump_target),
      .branch_taken(branch_taken), .branch_target(branch_target), .irq(irq), .eret(eret),
      .halt_req(halt_req), .nextPC(nextPC), .epc(epc), .irq_ack(irq_ack), .state(state)
   );

   always #5 CLK = ~CLK;

   // Reference model: core mode, saved return address, latched interrupt, expected ack.
   typedef enum int {M_RUN = 0, M_TRAP = 1, M_HALT = 2} mode_t;
   mode_t       m_mode = M_RUN;
   logic [31:0] m_epc = 0;
   bit          m_pend = 0, m_ack = 0, m_valid = 0;

   function automatic void model_eval(output logic [31:0] npc, output mode_t nmode,
                                      output bit take, output logic [31:0] tepc);
      logic [31:0] after, target;
      bit          wants_irq;
      after     = PC + 32'd4;
      target    = jump ? jump_target : branch_taken ? branch_target : after;
      wants_irq = irq || m_pend;
      nmode = m_mode; take = 0; tepc = target; npc = target;
      if (m_mode == M_HALT) begin
         npc = PC;
         if (wants_irq) begin npc = 32'h80; nmode = M_TRAP; take = 1; tepc = after; end
      end else if (stall) begin
         npc = PC;
      end else if (m_mode == M_RUN && wants_irq) begin
         npc = 32'h80; nmode = M_TRAP; take = 1;
      end else if (m_mode == M_TRAP && eret) begin
         npc = m_epc; nmode = M_RUN;
      end else if (halt_req) begin
         npc = PC; nmode = M_HALT;
      end
      if (RST) npc = 32'h0;
   endfunction

   always @(posedge CLK) begin
      logic [31:0] npc, tepc;
      mode_t nmode;
      bit take;
      model_eval(npc, nmode, take, tepc);
      if (RST) begin
         m_mode = M_RUN; m_epc = 0; m_pend = 0; m_ack = 0; m_valid = 1;
      end else if (m_valid) begin
         if (take) begin m_epc = tepc; m_pend = 0; end
         else m_pend = m_pend || irq;
         m_ack  = take;
         m_mode = nmode;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge CLK) begin
      logic [31:0] npc, tepc;
      mode_t nmode;
      bit take;
      if (m_valid) begin
         model_eval(npc, nmode, take, tepc);
         chk("model.nextPC", nextPC, npc);
         chk("model.state", {30'd0, state}, 32'(m_mode));
         chk("model.epc", epc, m_epc);
         chk("model.irq_ack", {31'd0, irq_ack}, {31'd0, m_ack});
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      stall = 0; jump = 0; branch_taken = 0; irq = 0; eret = 0; halt_req = 0;
   endtask

   initial begin
      RST = 1; PC = 32'h40; jump_target = 0; branch_target = 0;
      idle();
      // 1 reset
      cyc(); cyc();
      #1;
      chk("rst.nextPC", nextPC, 32'h0);
      chk("rst.state", {30'd0, state}, 32'd0);
      chk("rst.epc", epc, 32'h0);
      chk("rst.irq_ack", {31'd0, irq_ack}, 32'd0);
      // 2 priority
      cyc(); RST = 0; PC = 32'h100; jump = 1; jump_target = 32'h200;
      branch_taken = 1; branch_target = 32'h300; #1;
      chk("prio.jump", nextPC, 32'h200);
      cyc(); jump = 0; #1;
      chk("prio.branch", nextPC, 32'h300);
      cyc(); branch_taken = 0; #1;
      chk("prio.seq", nextPC, 32'h104);
      cyc(); stall = 1; jump = 1; #1;
      chk("prio.stall", nextPC, 32'h100);
      // 3 trap and return
      cyc(); idle(); PC = 32'h10; irq = 1; #1;
      chk("trap.vec", nextPC, 32'h80);
      cyc(); irq = 0; PC = 32'h80; #1;
      chk("trap.state", {30'd0, state}, 32'd1);
      chk("trap.epc", epc, 32'h14);
      chk("trap.ack", {31'd0, irq_ack}, 32'd1);
      cyc(); irq = 1; PC = 32'h84; #1;
      chk("trap.ack_once", {31'd0, irq_ack}, 32'd0);
      chk("trap.masked", nextPC, 32'h88);
      cyc(); irq = 0; eret = 1; #1;
      chk("trap.eret", nextPC, 32'h14);
      cyc(); eret = 0; PC = 32'h14; #1;
      chk("trap.ret_state", {30'd0, state}, 32'd0);
      chk("trap.pending", nextPC, 32'h80);
      cyc(); #1;
      chk("trap.pend_epc", epc, 32'h18);
      cyc(); eret = 1;
      cyc(); eret = 0;
      // 4 stalled irq
      PC = 32'h20; stall = 1; irq = 1; #1;
      chk("stirq.hold", nextPC, 32'h20);
      cyc(); irq = 0; stall = 0; #1;
      chk("stirq.vec", nextPC, 32'h80);
      cyc(); #1;
      chk("stirq.epc", epc, 32'h24);
      eret = 1;
      cyc(); eret = 0;
      // 5 halt and wake
      PC = 32'h50; halt_req = 1; #1;
      chk("halt.hold", nextPC, 32'h50);
      cyc(); halt_req = 0; jump = 1; jump_target = 32'h200;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("halt.state", {30'd0, state}, 32'd2);
         chk("halt.pc", nextPC, 32'h50);
         cyc();
      end
      irq = 1; #1;
      chk("wake.vec", nextPC, 32'h80);
      cyc(); irq = 0; jump = 0; #1;
      chk("wake.state", {30'd0, state}, 32'd1);
      chk("wake.epc", epc, 32'h54);
      // 6 wrap and reset mid-trap
      PC = 32'hFFFF_FFFC; #1;
      chk("wrap", nextPC, 32'h0);
      cyc(); RST = 1;
      cyc(); RST = 0; #1;
      chk("rst_trap.state", {30'd0, state}, 32'd0);
      chk("rst_trap.epc", epc, 32'h0);
      // random phase
      for (int i = 0; i < 3000; i++) begin
         cyc();
         RST           = ($urandom_range(99) < 2);
         PC            = {$urandom_range(32'h3FFF_FFFF), 2'b00};
         stall         = ($urandom_range(99) < 20);
         jump          = ($urandom_range(99) < 25);
         branch_taken  = ($urandom_range(99) < 25);
         jump_target   = $urandom;
         branch_target = $urandom;
         irq           = ($urandom_range(99) < 8);
         eret          = ($urandom_range(99) < 20);
         halt_req      = ($urandom_range(99) < 6);
      end
      cyc(); idle(); RST = 0;
      cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
